// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states
// and the iteration-counter width helper.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Counter must be able to hold WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative magnitude multiplier / restoring divider, one step per cycle.
// hi/lo hold {product_hi, product_lo} for mul and {remainder, quotient} for div.
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;

  always_comb begin
    mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    div_sh   = {hi_reg, lo_reg[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_reg};
    hi_next  = mul_sum[WIDTH:1];
    lo_next  = {mul_sum[0], lo_reg[WIDTH-1:1]};
    if (is_div) begin
      // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
      if (div_sh >= {1'b0, b_reg}) begin
        hi_next = div_diff[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = div_sh[WIDTH-1:0];
        lo_next = {lo_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
      b_reg   <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(WIDTH);
      hi_reg  <= '0;
      lo_reg  <= mag_a;
      b_reg   <= mag_b;
    end else if (run) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
    end
  end

  assign last = (cnt_reg == CNT_W'(1));
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised sequential ALU with start/busy/done handshake. Add/sub finish
// in one cycle; mul/div iterate WIDTH steps in seq_muldiv_core on magnitudes.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         select,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow,
  output logic               negative,
  output logic               zero,
  output logic               carry_out,
  output logic               divisionBy0
);

  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_reg, state_next;

  logic [1:0]         op_reg;
  logic               sm_reg, dbz_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b, core_hi, core_lo;
  logic               core_last;

  logic               done_reg, ovf_reg, neg_reg, zero_reg, carry_reg, dbz_out_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic [2*WIDTH-1:0] res_next, prod_mag, prod_s;
  logic               ovf_next, neg_next, zero_next, carry_next, dbz_next;
  logic [WIDTH:0]     as_full;
  logic [WIDTH-1:0]   addend, quo_s, rem_s;
  logic [WIDTH:0]     prod_top;
  logic               a_neg, b_neg, is_sub, sign_ovf;

  assign accept = (state_reg == IDLE) && start;
  assign mag_a  = (signed_mode && A[WIDTH-1]) ? ('0 - A) : A;
  assign mag_b  = (signed_mode && B[WIDTH-1]) ? ('0 - B) : B;

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .run    (state_reg == RUN),
    .is_div (op_reg == OP_DIV),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .last   (core_last),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) begin
        if (select == OP_MUL || (select == OP_DIV && B != '0)) state_next = RUN;
        else                                                     state_next = FIN;
      end
      RUN:     if (core_last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg  <= OP_ADD;
      sm_reg  <= 1'b0;
      dbz_reg <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else if (accept) begin
      op_reg  <= select;
      sm_reg  <= signed_mode;
      dbz_reg <= (select == OP_DIV) && (B == '0);
      a_reg   <= A;
      b_reg   <= B;
    end
  end

  // Result and flags from the latched operands and the core's magnitudes.
  always_comb begin
    a_neg      = sm_reg & a_reg[WIDTH-1];
    b_neg      = sm_reg & b_reg[WIDTH-1];
    is_sub     = (op_reg == OP_SUB);
    addend     = is_sub ? ~b_reg : b_reg;
    as_full    = {1'b0, a_reg} + {1'b0, addend} + {{WIDTH{1'b0}}, is_sub};
    sign_ovf   = (a_reg[WIDTH-1] == addend[WIDTH-1]) && (as_full[WIDTH-1] != a_reg[WIDTH-1]);
    prod_mag   = {core_hi, core_lo};
    prod_s     = (a_neg ^ b_neg) ? ('0 - prod_mag) : prod_mag;
    prod_top   = prod_s[2*WIDTH-1:WIDTH-1];
    quo_s      = (a_neg ^ b_neg) ? ('0 - core_lo) : core_lo;
    rem_s      = a_neg ? ('0 - core_hi) : core_hi;
    res_next   = '0;
    ovf_next   = 1'b0;
    neg_next   = 1'b0;
    zero_next  = 1'b0;
    carry_next = 1'b0;
    dbz_next   = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        res_next   = {{WIDTH{1'b0}}, as_full[WIDTH-1:0]};
        carry_next = as_full[WIDTH];
        ovf_next   = sm_reg ? sign_ovf : (is_sub ? ~as_full[WIDTH] : as_full[WIDTH]);
        neg_next   = sm_reg ? as_full[WIDTH-1] : (is_sub & ~as_full[WIDTH]);
        zero_next  = (as_full[WIDTH-1:0] == '0);
      end
      OP_MUL: begin
        res_next  = prod_s;
        ovf_next  = sm_reg ? ~((&prod_top) | ~(|prod_top)) : (|prod_mag[2*WIDTH-1:WIDTH]);
        neg_next  = sm_reg & prod_s[2*WIDTH-1];
        zero_next = (prod_s == '0);
      end
      default: begin
        if (dbz_reg) begin
          res_next = {{WIDTH{1'b1}}, a_reg};
          dbz_next = 1'b1;
          neg_next = sm_reg;
        end else begin
          // MIN / -1: magnitude quotient 2^(WIDTH-1) already reads as MIN.
          res_next  = {quo_s, rem_s};
          ovf_next  = sm_reg && (a_reg == S_MIN) && (&b_reg);
          neg_next  = sm_reg & quo_s[WIDTH-1];
          zero_next = (quo_s == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_reg    <= 1'b0;
      result_reg  <= '0;
      ovf_reg     <= 1'b0;
      neg_reg     <= 1'b0;
      zero_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      dbz_out_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIN);
      if (state_reg == FIN) begin
        result_reg  <= res_next;
        ovf_reg     <= ovf_next;
        neg_reg     <= neg_next;
        zero_reg    <= zero_next;
        carry_reg   <= carry_next;
        dbz_out_reg <= dbz_next;
      end
    end
  end

  assign done        = done_reg;
  assign result      = result_reg;
  assign overflow    = ovf_reg;
  assign negative    = neg_reg;
  assign zero        = zero_reg;
  assign carry_out   = carry_reg;
  assign divisionBy0 = dbz_out_reg;

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised self-checking bench for alu_seq_param (WIDTH=8) against an
// arithmetic reference model, plus directed cases and a mid-operation reset.
module tb_alu_seq_param;

  localparam int W  = 8;
  localparam int W2 = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    select = 2'b00;
  logic          signed_mode = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          busy, done, overflow, negative, zero, carry_out, divisionBy0;
  logic [W2-1:0] result;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .select      (select),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .negative    (negative),
    .zero        (zero),
    .carry_out   (carry_out),
    .divisionBy0 (divisionBy0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W2-1:0] res;
    logic          ovf, neg, zero, carry, dbz;
    int            cyc;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t last_e;
  bit   have_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.res = '0; e.ovf = 0; e.neg = 0; e.zero = 0; e.carry = 0; e.dbz = 0; e.cyc = 0;
    return e;
  endfunction

  // Reference model: plain integer arithmetic on the operands' numeric values.
  function automatic exp_t model(input logic [1:0] op, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint modw, lim_hi, lim_lo, ua, ub, va, vb, r, qq, rm, low;
    e = zero_exp();
    modw   = longint'(1) << W;
    lim_hi = modw / 2 - 1;
    lim_lo = -(modw / 2);
    ua = longint'(a);
    ub = longint'(b);
    va = (s && a[W-1]) ? ua - modw : ua;
    vb = (s && b[W-1]) ? ub - modw : ub;
    case (op)
      2'd0, 2'd1: begin
        r       = (op == 2'd0) ? va + vb : va - vb;
        low     = r & (modw - 1);
        e.res   = W2'(low);
        e.carry = (op == 2'd0) ? (ua + ub >= modw) : (ua >= ub);
        if (s)            e.ovf = (r > lim_hi) || (r < lim_lo);
        else if (op == 0) e.ovf = e.carry;
        else              e.ovf = (ua < ub);
        if (s)            e.neg = (low >= modw / 2);
        else              e.neg = (op == 2'd1) && (ua < ub);
        e.zero  = (low == 0);
      end
      2'd2: begin
        r      = va * vb;
        e.res  = W2'(r & (modw * modw - 1));
        e.ovf  = s ? ((r > lim_hi) || (r < lim_lo)) : (r > modw - 1);
        e.neg  = s && (r < 0);
        e.zero = (r == 0);
      end
      default: begin
        if (ub == 0) begin
          qq = modw - 1; rm = ua; e.dbz = 1; e.neg = s;
        end else if (s && va == lim_lo && vb == -1) begin
          qq = lim_lo; rm = 0; e.ovf = 1; e.neg = 1;
        end else begin
          qq = va / vb; rm = va % vb; e.neg = s && (qq < 0);
        end
        e.res  = W2'(((qq & (modw - 1)) << W) | (rm & (modw - 1)));
        e.zero = (qq == 0) && (ub != 0);
      end
    endcase
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, "_result"},   64'(result),      64'(e.res));
    chk({tag, "_overflow"}, 64'(overflow),    64'(e.ovf));
    chk({tag, "_negative"}, 64'(negative),    64'(e.neg));
    chk({tag, "_zero"},     64'(zero),        64'(e.zero));
    chk({tag, "_carry"},    64'(carry_out),   64'(e.carry));
    chk({tag, "_divby0"},   64'(divisionBy0), 64'(e.dbz));
  endtask

  // Single compare process: done timing/values on done cycles, held values otherwise.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          cmp_out("done", e);
          last_e    = e;
          have_last = 1;
        end
      end else begin
        if (q.size() > 0 && cyc > q[0].cyc) begin
          chk("done_missing", 64'(cyc), 64'(q[0].cyc));
          void'(q.pop_front());
        end
        if (have_last) cmp_out("hold", last_e);
      end
    end
  end

  // Inputs wander while busy; start pulses while busy must be ignored.
  task automatic scramble();
    A           = W'($urandom);
    B           = W'($urandom);
    select      = 2'($urandom_range(0, 3));
    signed_mode = 1'($urandom_range(0, 1));
    start       = (busy === 1'b1) && ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      scramble();
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int   waited;
    int   lat;
    exp_t e;
    waited = 0;
    while (busy !== 1'b0 && waited < 200) begin
      scramble();
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) chk("busy_timeout", 64'(busy), 64'd0);
    select = op; signed_mode = s; A = a; B = b; start = 1'b1;
    lat = (op == 2'd2 || (op == 2'd3 && b != '0)) ? W + 1 : 1;
    e = model(op, s, a, b);
    e.cyc = cyc + 1 + lat;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pin(input string name, input exp_t got, input logic [W2-1:0] r,
                     input logic ovf, input logic neg, input logic z, input logic c, input logic d);
    chk({name, "_res"},  64'(got.res),  64'(r));
    chk({name, "_flags"}, {59'd0, got.ovf, got.neg, got.zero, got.carry, got.dbz},
        {59'd0, ovf, neg, z, c, d});
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    last_e    = zero_exp();
    have_last = 1;

    // Hand-computed values that pin the reference model.
    pin("m_add_u",   model(2'd0, 0, 8'd255, 8'd1),  16'h0000, 1, 0, 1, 1, 0);
    pin("m_add_s",   model(2'd0, 1, 8'd100, 8'd100), 16'h00C8, 1, 1, 0, 0, 0);
    pin("m_sub_u",   model(2'd1, 0, 8'd8, 8'd15),    16'h00F9, 1, 1, 0, 0, 0);
    pin("m_sub_z",   model(2'd1, 0, 8'd20, 8'd20),   16'h0000, 0, 0, 1, 1, 0);
    pin("m_mul_u",   model(2'd2, 0, 8'd15, 8'd8),    16'd120,  0, 0, 0, 0, 0);
    pin("m_mul_s",   model(2'd2, 1, 8'hFD, 8'd5),    16'hFFF1, 0, 1, 0, 0, 0);
    pin("m_mul_ovf", model(2'd2, 0, 8'd200, 8'd2),   16'd400,  1, 0, 0, 0, 0);
    pin("m_div_u",   model(2'd3, 0, 8'd15, 8'd8),    16'h0107, 0, 0, 0, 0, 0);
    pin("m_div_s",   model(2'd3, 1, 8'hF9, 8'd2),    16'hFDFF, 0, 1, 0, 0, 0);
    pin("m_div_min", model(2'd3, 1, 8'h80, 8'hFF),   16'h8000, 1, 1, 0, 0, 0);
    pin("m_div_0",   model(2'd3, 0, 8'd15, 8'd0),    16'hFF0F, 0, 0, 0, 0, 1);

    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    cmp_out("reset", zero_exp());
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);

    // Directed cases, issued back-to-back where the previous op allows.
    do_op(2'd0, 0, 8'd255, 8'd1);
    do_op(2'd0, 1, 8'd100, 8'd100);
    do_op(2'd1, 0, 8'd8, 8'd15);
    do_op(2'd1, 0, 8'd20, 8'd20);
    do_op(2'd2, 0, 8'd15, 8'd8);
    do_op(2'd2, 1, 8'hFD, 8'd5);
    do_op(2'd2, 0, 8'd200, 8'd2);
    do_op(2'd3, 0, 8'd15, 8'd8);
    do_op(2'd3, 1, 8'hF9, 8'd2);
    do_op(2'd3, 1, 8'h80, 8'hFF);
    do_op(2'd3, 0, 8'd15, 8'd0);
    do_op(2'd0, 0, 8'd1, 8'd2);

    // Reset in the middle of a division: no done, everything returns to zero.
    do_op(2'd3, 0, 8'd200, 8'd7);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    q.delete();
    last_e    = zero_exp();
    have_last = 1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    cmp_out("midrst", zero_exp());
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    idle(15);

    // Randomised mix with forced corner operands and occasional gaps.
    for (int i = 0; i < 200; i++) begin
      logic [1:0]   op;
      logic         s;
      logic [W-1:0] a, b;
      int           k;
      op = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      b  = W'($urandom);
      k  = $urandom_range(0, 9);
      if (k == 0) b = '0;
      if (k == 1) begin a = 8'h80; b = 8'hFF; end
      if (k == 2) a = '0;
      do_op(op, s, a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
